// File: rtl/ball_split_ctrl_if.sv
// Collision/frame inputs and ball-control outputs of ball_split_ctrl, grouped as one bundle.
// No handshake: every field is a plain level or one-cycle pulse.
interface ball_split_ctrl_if;
  logic        startOfFrame;
  logic        levelStart;
  logic        hitHuge;
  logic        hitBig1;
  logic        hitBig2;
  logic [10:0] hugeTopLeftX;
  logic [10:0] hugeTopLeftY;
  logic        hugeActive;
  logic        big1Active;
  logic        big2Active;
  logic        bigSpawn;
  logic [10:0] spawn1X;
  logic [10:0] spawn2X;
  logic [10:0] spawnY;
  logic        shotClear;
  logic        levelCleared;
  logic [7:0]  scoreAdd;

  modport master (
    output startOfFrame, levelStart, hitHuge, hitBig1, hitBig2, hugeTopLeftX, hugeTopLeftY,
    input  hugeActive, big1Active, big2Active, bigSpawn, spawn1X, spawn2X, spawnY,
           shotClear, levelCleared, scoreAdd
  );

  modport slave (
    input  startOfFrame, levelStart, hitHuge, hitBig1, hitBig2, hugeTopLeftX, hugeTopLeftY,
    output hugeActive, big1Active, big2Active, bigSpawn, spawn1X, spawn2X, spawnY,
           shotClear, levelCleared, scoreAdd
  );
endinterface

// File: rtl/ball_split_ctrl.sv
// Huge/big ball life-cycle, split and level-clear sequencing; scoring only when BALL_SPLIT_SCORE_EN is defined.
// All outputs registered one cycle after the sampled inputs; no backpressure, hits are level inputs.
module ball_split_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int BIG_W        = 32,
  parameter int SPLIT_OFFSET = 48,
  parameter int GRACE_FRAMES = 8
) (
  input  logic              clk,
  input  logic              resetN,
  ball_split_ctrl_if.slave  bus
);

  localparam int          GW        = $clog2(GRACE_FRAMES + 1);
  localparam logic [11:0] SPAWN_MAX = 12'(SCREEN_W - BIG_W);

  typedef enum logic [2:0] {IDLE, HUGE_LIVE, SPLIT, BIG_LIVE, CLEARED} state_t;

  state_t          state, state_nxt;
  logic            huge_act, huge_act_nxt;
  logic            big1_act, big1_act_nxt;
  logic            big2_act, big2_act_nxt;
  logic            spawn, spawn_nxt;
  logic            shot, shot_nxt;
  logic            clr, clr_nxt;
  logic [10:0]     cap_x, cap_x_nxt, cap_y, cap_y_nxt;
  logic [10:0]     s1x, s1x_nxt, s2x, s2x_nxt, sy, sy_nxt;
  logic [GW-1:0]   grace, grace_nxt;
  logic [11:0]     sum_x;
  logic [10:0]     clamp_x;
  logic            kill1, kill2;

  // 12-bit sum so a huge ball near the right edge clamps instead of wrapping
  assign sum_x   = {1'b0, cap_x} + 12'(SPLIT_OFFSET);
  assign clamp_x = (sum_x > SPAWN_MAX) ? SPAWN_MAX[10:0] : sum_x[10:0];

  assign kill1 = (state == BIG_LIVE) && (grace == '0) && bus.hitBig1 && big1_act && !bus.levelStart;
  assign kill2 = (state == BIG_LIVE) && (grace == '0) && bus.hitBig2 && big2_act && !bus.levelStart;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      huge_act <= 1'b0;
      big1_act <= 1'b0;
      big2_act <= 1'b0;
      spawn    <= 1'b0;
      shot     <= 1'b0;
      clr      <= 1'b0;
      cap_x    <= '0;
      cap_y    <= '0;
      s1x      <= '0;
      s2x      <= '0;
      sy       <= '0;
      grace    <= '0;
    end else begin
      state    <= state_nxt;
      huge_act <= huge_act_nxt;
      big1_act <= big1_act_nxt;
      big2_act <= big2_act_nxt;
      spawn    <= spawn_nxt;
      shot     <= shot_nxt;
      clr      <= clr_nxt;
      cap_x    <= cap_x_nxt;
      cap_y    <= cap_y_nxt;
      s1x      <= s1x_nxt;
      s2x      <= s2x_nxt;
      sy       <= sy_nxt;
      grace    <= grace_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    huge_act_nxt = huge_act;
    big1_act_nxt = big1_act;
    big2_act_nxt = big2_act;
    spawn_nxt    = 1'b0;
    shot_nxt     = 1'b0;
    clr_nxt      = 1'b0;
    cap_x_nxt    = cap_x;
    cap_y_nxt    = cap_y;
    s1x_nxt      = s1x;
    s2x_nxt      = s2x;
    sy_nxt       = sy;
    grace_nxt    = grace;

    // levelStart starts a level from IDLE and aborts one from any other state
    if (bus.levelStart) begin
      state_nxt    = HUGE_LIVE;
      huge_act_nxt = 1'b1;
      big1_act_nxt = 1'b0;
      big2_act_nxt = 1'b0;
      grace_nxt    = '0;
    end else begin
      case (state)
        IDLE: ;
        HUGE_LIVE: begin
          if (bus.hitHuge) begin
            cap_x_nxt    = bus.hugeTopLeftX;
            cap_y_nxt    = bus.hugeTopLeftY;
            huge_act_nxt = 1'b0;
            shot_nxt     = 1'b1;
            state_nxt    = SPLIT;
          end
        end
        SPLIT: begin
          spawn_nxt    = 1'b1;
          s1x_nxt      = cap_x;
          s2x_nxt      = clamp_x;
          sy_nxt       = cap_y;
          big1_act_nxt = 1'b1;
          big2_act_nxt = 1'b1;
          grace_nxt    = GW'(GRACE_FRAMES);
          state_nxt    = BIG_LIVE;
        end
        BIG_LIVE: begin
          if (bus.startOfFrame && (grace != '0))
            grace_nxt = grace - GW'(1);
          if (kill1)
            big1_act_nxt = 1'b0;
          if (kill2)
            big2_act_nxt = 1'b0;
          shot_nxt = kill1 | kill2;
          if (!(big1_act && !kill1) && !(big2_act && !kill2))
            state_nxt = CLEARED;
        end
        CLEARED: begin
          clr_nxt   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef BALL_SPLIT_SCORE_EN
  logic [7:0] score, score_nxt;

  always_comb begin
    score_nxt = 8'd0;
    if ((state == HUGE_LIVE) && bus.hitHuge && !bus.levelStart)
      score_nxt = 8'd10;
    else if (kill1 && kill2)
      score_nxt = 8'd40;
    else if (kill1 || kill2)
      score_nxt = 8'd20;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      score <= 8'd0;
    else
      score <= score_nxt;
  end

  assign bus.scoreAdd = score;
`else
  assign bus.scoreAdd = 8'd0;
`endif

  assign bus.hugeActive   = huge_act;
  assign bus.big1Active   = big1_act;
  assign bus.big2Active   = big2_act;
  assign bus.bigSpawn     = spawn;
  assign bus.spawn1X      = s1x;
  assign bus.spawn2X      = s2x;
  assign bus.spawnY       = sy;
  assign bus.shotClear    = shot;
  assign bus.levelCleared = clr;

endmodule
